// File: rtl/inst_mem_loader_pkg.sv
// Shared types and widths for the instruction-memory loader and its neighbours
// (the PC and instruction-memory blocks use INST_W and PC_W as well).
package inst_mem_loader_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 8;

  typedef enum logic [2:0] {
    IML_IDLE  = 3'd0,
    IML_LEN   = 3'd1,
    IML_DATA  = 3'd2,
    IML_WRITE = 3'd3,
    IML_DONE  = 3'd4,
    IML_ERR   = 3'd5
  } iml_state_e;

  // A program length byte is usable only if it is non-zero and fits the memory.
  function automatic logic len_legal(input logic [7:0] len, input logic [7:0] max_words);
    return (len != 8'd0) && (len <= max_words);
  endfunction

endpackage

// File: rtl/iml_word_asm.sv
// Big-endian word assembler: shifts bytes in MSB-first and counts them,
// flagging when the byte being offered completes the word.
module iml_word_asm #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              clr,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word_out,
  output logic              last_byte
);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [1:0]        cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clr) begin
      sr_d  = '0;
      cnt_d = 2'd0;
    end else if (shift_en) begin
      sr_d  = {sr_q[WORD_W-9:0], byte_in};
      cnt_d = cnt_q + 2'd1;
    end
  end

  // word_out is the post-shift value, so the word completed by the 4th byte
  // can be captured on the same edge that accepts it.
  assign word_out  = sr_d;
  assign last_byte = (cnt_q == 2'd3);

  // NOTE: sequential state uses non-blocking assignments only; the next-state
  // values come from the always_comb above.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Fills instruction memory from a length-prefixed byte stream and holds the CPU
// until the whole program has been written.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int ADDR_W  = PC_W,
  parameter int WORD_W  = INST_W,
  parameter int N_WORDS = 64
) (
  input  logic              clk_IML,
  input  logic              rstn_IML,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [6:0]        word_count
);

  localparam int         IDX_W = $clog2(N_WORDS);
  localparam logic [7:0] N_MAX = 8'(N_WORDS);

  iml_state_e        state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic [6:0]        word_count_q, word_count_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cpu_hold_q, cpu_hold_d;

  logic              asm_shift, asm_clr, asm_last;
  logic [WORD_W-1:0] asm_word;
  logic              xfer;
  logic [7:0]        idx_next;

  iml_word_asm #(.WORD_W(WORD_W)) u_word_asm (
    .clk       (clk_IML),
    .rst_n     (rstn_IML),
    .shift_en  (asm_shift),
    .clr       (asm_clr),
    .byte_in   (byte_data),
    .word_out  (asm_word),
    .last_byte (asm_last)
  );

  assign byte_ready = (state_q == IML_LEN) || (state_q == IML_DATA);
  assign xfer       = byte_valid && byte_ready;
  assign idx_next   = 8'(word_idx_q) + 8'd1;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    word_count_d = word_count_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_d       = done_q;
    err_d        = err_q;
    cpu_hold_d   = cpu_hold_q;
    asm_shift    = 1'b0;
    asm_clr      = 1'b0;

    unique case (state_q)
      IML_IDLE: begin
        if (start) state_d = IML_LEN;
      end
      IML_LEN: begin
        if (xfer) begin
          if (!len_legal(byte_data, N_MAX)) begin
            state_d = IML_ERR;
            err_d   = 1'b1;
          end else begin
            state_d      = IML_DATA;
            len_d        = byte_data;
            word_idx_d   = '0;
            word_count_d = 7'd0;
            asm_clr      = 1'b1;
          end
        end
      end
      IML_DATA: begin
        if (xfer) begin
          asm_shift = 1'b1;
          if (asm_last) begin
            state_d   = IML_WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_W'({word_idx_q, 2'b00});
            wr_data_d = asm_word;
          end
        end
      end
      IML_WRITE: begin
        word_count_d = word_count_q + 7'd1;
        // The index stays on the last word so it never reaches N_WORDS.
        if (idx_next == len_q) begin
          state_d    = IML_DONE;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
        end else begin
          state_d    = IML_DATA;
          word_idx_d = idx_next[IDX_W-1:0];
        end
      end
      IML_DONE: begin
        if (start) begin
          state_d    = IML_LEN;
          done_d     = 1'b0;
          cpu_hold_d = 1'b1;
        end
      end
      IML_ERR: begin
        if (start) begin
          state_d = IML_LEN;
          err_d   = 1'b0;
        end
      end
      default: state_d = IML_IDLE;
    endcase
  end

  always_ff @(posedge clk_IML) begin
    if (!rstn_IML) begin
      state_q      <= IML_IDLE;
      len_q        <= 8'd0;
      word_idx_q   <= '0;
      word_count_q <= 7'd0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      word_count_q <= word_count_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cpu_hold_q   <= cpu_hold_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign done       = done_q;
  assign err        = err_q;
  assign cpu_hold   = cpu_hold_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: a cycle-by-cycle vector table plus
// streamed loads with bubbles, maximum length and a mid-session reset.
module tb_inst_mem_loader;

  logic        clk_IML = 1'b0;
  logic        rstn_IML;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [6:0]  word_count;

  int total = 0;
  int bad   = 0;

  inst_mem_loader dut (
    .clk_IML    (clk_IML),
    .rstn_IML   (rstn_IML),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk_IML = ~clk_IML;

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic        ready;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        done;
    logic        hold;
    logic        err;
    logic [6:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_IML);
    #1;
  endtask

  function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d,
                              input logic r, input logic w, input logic [7:0] a,
                              input logic [31:0] wd, input logic dn, input logic h,
                              input logic e, input logic [6:0] c);
    vec_t t;
    t.start = s; t.valid = v; t.data = d; t.ready = r; t.we = w; t.addr = a;
    t.wdata = wd; t.done = dn; t.hold = h; t.err = e; t.cnt = c;
    return t;
  endfunction

  // Program word i used by the streamed loads.
  function automatic logic [31:0] exp_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, b ^ 8'h5A, b + 8'h30, ~b};
  endfunction

  // Byte k of a stream carrying len words: length byte first, then MSB-first words.
  function automatic logic [7:0] stream_byte(input int len, input int k);
    logic [31:0] w;
    if (k == 0) return 8'(len);
    w = exp_word((k - 1) / 4);
    return w[31 - 8 * ((k - 1) % 4) -: 8];
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_hold"},  32'(cpu_hold),   32'd1);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_en),      32'd0);
    check({tag, "_done"},  32'(done),       32'd0);
    check({tag, "_err"},   32'(err),        32'd0);
  endtask

  task automatic run_load(input int len, input bit bubbles);
    int   nbytes;
    int   ptr;
    int   writes;
    int   cyc;
    logic rdy;
    nbytes = 1 + 4 * len;
    ptr = 0; writes = 0; cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("load_enter_len_ready", 32'(byte_ready), 32'd1);
    check("load_enter_len_done",  32'(done),       32'd0);
    while (!done && cyc < 2000) begin
      byte_valid = (ptr < nbytes) && (bubbles ? ($urandom_range(0, 1) == 1) : 1'b1);
      byte_data  = (ptr < nbytes) ? stream_byte(len, ptr) : 8'h00;
      rdy = byte_ready;
      step();
      if (byte_valid && rdy) ptr++;
      if (wr_en) begin
        check("load_wr_addr",     32'(wr_addr),    32'(writes * 4));
        check("load_wr_data",     wr_data,         exp_word(writes));
        check("load_ready_in_wr", 32'(byte_ready), 32'd0);
        writes++;
      end
      cyc++;
    end
    byte_valid = 1'b0;
    check("load_timeout",    32'(cyc < 2000), 32'd1);
    check("load_writes",     32'(writes),     32'(len));
    check("load_bytes_used", 32'(ptr),        32'(nbytes));
    check("load_word_count", 32'(word_count), 32'(len));
    check("load_hold",       32'(cpu_hold),   32'd0);
    check("load_err",        32'(err),        32'd0);
  endtask

  initial begin
    int xfers;
    int cyc;
    logic rdy;

    rstn_IML = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    step();
    step();
    check_idle_outputs("reset");
    check("reset_count", 32'(word_count), 32'd0);
    check("reset_addr",  32'(wr_addr),    32'd0);
    check("reset_data",  wr_data,         32'd0);

    // Idle after reset: no start, stray bytes must not be taken.
    rstn_IML = 1'b1;
    for (int i = 0; i < 12; i++) begin
      byte_valid = i[0];
      byte_data  = 8'h01;
      step();
      check_idle_outputs("idle");
    end
    byte_valid = 1'b0;

    //             st v  data    rdy we addr   wdata         dn hd er cnt
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 32'h0,        0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h01, 1, 0, 8'h00, 32'h0,        0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h8C, 1, 0, 8'h00, 32'h0,        0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h22, 1, 0, 8'h00, 32'h0,        0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 0, 8'h00, 32'h0,        0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h04, 0, 1, 8'h00, 32'h8C220004, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'hAA, 0, 0, 8'h00, 32'h8C220004, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 32'h8C220004, 1, 0, 0, 1));
    // reload from DONE with L=2; a byte offered during WRITE and a start in DATA are ignored
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 32'h8C220004, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 8'h02, 1, 0, 8'h00, 32'h8C220004, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h11, 1, 0, 8'h00, 32'h8C220004, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h22, 1, 0, 8'h00, 32'h8C220004, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h33, 1, 0, 8'h00, 32'h8C220004, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h44, 0, 1, 8'h00, 32'h11223344, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h55, 1, 0, 8'h00, 32'h11223344, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 8'h55, 1, 0, 8'h00, 32'h11223344, 0, 1, 0, 1));
    vecs.push_back(mk(1, 1, 8'h66, 1, 0, 8'h00, 32'h11223344, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 8'h77, 1, 0, 8'h00, 32'h11223344, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 8'h88, 0, 1, 8'h04, 32'h55667788, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h04, 32'h55667788, 1, 0, 0, 2));
    // illegal lengths 00 and 41, then recovery with L=1
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 8'h04, 32'h55667788, 0, 1, 0, 2));
    vecs.push_back(mk(0, 1, 8'h00, 0, 0, 8'h04, 32'h55667788, 0, 1, 1, 2));
    vecs.push_back(mk(0, 1, 8'h05, 0, 0, 8'h04, 32'h55667788, 0, 1, 1, 2));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 8'h04, 32'h55667788, 0, 1, 0, 2));
    vecs.push_back(mk(0, 1, 8'h41, 0, 0, 8'h04, 32'h55667788, 0, 1, 1, 2));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 8'h04, 32'h55667788, 0, 1, 0, 2));
    vecs.push_back(mk(0, 1, 8'h01, 1, 0, 8'h04, 32'h55667788, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'hDE, 1, 0, 8'h04, 32'h55667788, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'hAD, 1, 0, 8'h04, 32'h55667788, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'hBE, 1, 0, 8'h04, 32'h55667788, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'hEF, 0, 1, 8'h00, 32'hDEADBEEF, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 32'hDEADBEEF, 1, 0, 0, 1));

    foreach (vecs[i]) begin
      start      = vecs[i].start;
      byte_valid = vecs[i].valid;
      byte_data  = vecs[i].data;
      step();
      check($sformatf("vec%0d_ready", i), 32'(byte_ready), 32'(vecs[i].ready));
      check($sformatf("vec%0d_wr_en", i), 32'(wr_en),      32'(vecs[i].we));
      check($sformatf("vec%0d_addr", i),  32'(wr_addr),    32'(vecs[i].addr));
      check($sformatf("vec%0d_wdata", i), wr_data,         vecs[i].wdata);
      check($sformatf("vec%0d_done", i),  32'(done),       32'(vecs[i].done));
      check($sformatf("vec%0d_hold", i),  32'(cpu_hold),   32'(vecs[i].hold));
      check($sformatf("vec%0d_err", i),   32'(err),        32'(vecs[i].err));
      check($sformatf("vec%0d_count", i), 32'(word_count), 32'(vecs[i].cnt));
    end
    start = 1'b0; byte_valid = 1'b0;

    // Back-pressure: random bubbles on byte_valid, L=3.
    run_load(3, 1'b1);
    // Maximum program length: word_count reaches N_WORDS, last address FC.
    run_load(64, 1'b0);

    // Mid-session abort: L=4, reset after 6 accepted bytes.
    start = 1'b1;
    step();
    start = 1'b0;
    xfers = 0; cyc = 0;
    while (xfers < 6 && cyc < 50) begin
      byte_valid = 1'b1;
      byte_data  = stream_byte(4, xfers);
      rdy = byte_ready;
      step();
      if (rdy) xfers++;
      cyc++;
    end
    check("abort_bytes_taken", 32'(xfers), 32'd6);
    byte_valid = 1'b0;
    rstn_IML = 1'b0;
    step();
    check_idle_outputs("abort");
    check("abort_count", 32'(word_count), 32'd0);
    check("abort_addr",  32'(wr_addr),    32'd0);
    check("abort_data",  wr_data,         32'd0);
    rstn_IML = 1'b1;
    step();
    check_idle_outputs("abort_idle");
    run_load(4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
